// File: rtl/dcache_mem_responder.sv
// Main-memory responder for the data-cache refill/write-back port.
// Accepts one 256-bit line read or write, holds it for LATENCY cycles,
// then completes it with a single-cycle ack. The backing store has no
// reset so it can map onto RAM and keep its contents across a reset.
//
// state | meaning
// IDLE  | waiting for enable_i; request accepted at the first edge it is high
// WAIT  | latency count running on the latched request; inputs ignored
// ACK   | ack_o high for this one cycle; enable_i ignored, then back to IDLE
module dcache_mem_responder #(
  parameter int LATENCY = 10,
  parameter int DEPTH   = 512,
  parameter int IDX_W   = 9
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         enable_i,
  input  logic         write_i,
  input  logic [31:0]  addr_i,
  input  logic [255:0] data_i,
  output logic         ack_o,
  output logic [255:0] data_o,
  output logic         busy_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;

  // Completion happens at the edge where the counter reaches LATENCY-1,
  // which puts ack_o high in the LATENCY-th cycle after the accept edge.
  localparam logic [7:0] LAST_CNT = 8'(LATENCY - 1);

  state_t             state;
  logic [7:0]         counter;
  logic               wr_q;
  logic [IDX_W-1:0]   idx_q;
  logic [255:0]       data_q;
  logic [255:0]       mem [DEPTH];

  logic               done;
  logic               unused_addr;

  // Upper address bits alias onto the same line; byte offset is meaningless.
  assign unused_addr = ^{addr_i[31:IDX_W+5], addr_i[4:0]};

  assign done = (state == WAIT) && (counter == LAST_CNT);

  // Backing store write: only a latched write that reaches completion lands.
  // A reset during WAIT forces IDLE, so an aborted write never gets here.
  always_ff @(posedge clk_i) begin
    if (done && wr_q) begin
      mem[idx_q] <= data_q;
    end
  end

  // Request sequencing, latched request copy and registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= IDLE;
      counter <= 8'd0;
      ack_o   <= 1'b0;
      data_o  <= '0;
      busy_o  <= 1'b0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      data_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (enable_i) begin
            wr_q    <= write_i;
            idx_q   <= addr_i[IDX_W+4:5];
            data_q  <= data_i;
            counter <= 8'd1;
            state   <= WAIT;
            busy_o  <= 1'b1;
          end
        end
        WAIT: begin
          counter <= counter + 8'd1;
          if (counter == LAST_CNT) begin
            state <= ACK;
            ack_o <= 1'b1;
            if (!wr_q) begin
              data_o <= mem[idx_q];
            end
          end
        end
        ACK: begin
          // A requester still holding enable_i here is not re-accepted.
          ack_o   <= 1'b0;
          counter <= 8'd0;
          state   <= IDLE;
          busy_o  <= 1'b0;
        end
        default: begin
          ack_o   <= 1'b0;
          counter <= 8'd0;
          state   <= IDLE;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_mem_responder.sv
// Scoreboard bench for dcache_mem_responder: the driver pushes the expected
// data_o of each request; a monitor pops and checks on every ack pulse.
module tb_dcache_mem_responder;

  localparam int LAT = 10;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         enable_i, write_i;
  logic [31:0]  addr_i;
  logic [255:0] data_i;
  logic         ack_o, busy_o;
  logic [255:0] data_o;

  logic         en2, wr2;
  logic [31:0]  a2;
  logic [255:0] d2;
  logic         ack2, busy2;
  logic [255:0] dout2;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [255:0] exp_q [$];
  logic [255:0] model_mem [512];
  logic [255:0] model_dout;

  int  busy_cnt  = 0;
  bit  after_ack = 0;
  int  last_ack  = 0;
  int  prev_ack  = 0;

  dcache_mem_responder #(.LATENCY(LAT), .DEPTH(512), .IDX_W(9)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i), .write_i(write_i),
    .addr_i(addr_i), .data_i(data_i), .ack_o(ack_o), .data_o(data_o),
    .busy_o(busy_o)
  );

  dcache_mem_responder #(.LATENCY(2), .DEPTH(512), .IDX_W(9)) dut2 (
    .clk_i(clk_i), .rst_i(rst_i), .enable_i(en2), .write_i(wr2),
    .addr_i(a2), .data_i(d2), .ack_o(ack2), .data_o(dout2),
    .busy_o(busy2)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: every ack must match the oldest expected entry, arrive after
  // exactly LAT busy cycles, and be followed by an idle, non-acking cycle.
  always @(negedge clk_i) begin
    if (rst_i) begin
      busy_cnt  = 0;
      after_ack = 0;
    end else begin
      if (busy_o) busy_cnt++;
      else busy_cnt = 0;
      if (after_ack) begin
        chk("ack_one_cycle", {255'b0, ack_o}, 256'd0);
        chk("idle_after_ack", {255'b0, busy_o}, 256'd0);
        after_ack = 0;
      end
      if (ack_o) begin
        prev_ack = last_ack;
        last_ack = cyc;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_ack actual=1 required=0");
        end else begin
          chk("data_o", data_o, exp_q.pop_front());
        end
        chk("latency", 256'(busy_cnt), 256'(LAT));
        after_ack = 1;
      end
    end
  end

  // Issue one request at a negedge and hold enable_i until ack is seen.
  task automatic req(input logic wr, input logic [31:0] addr, input logic [255:0] d,
                     input bit scramble, input bit keep_en);
    bit got;
    logic [8:0] idx;
    idx = addr[13:5];
    if (wr) begin
      model_mem[idx] = d;
    end else begin
      model_dout = model_mem[idx];
    end
    exp_q.push_back(model_dout);
    write_i  = wr;
    addr_i   = addr;
    data_i   = d;
    enable_i = 1'b1;
    got = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_i);
      if (ack_o) begin
        got = 1;
        break;
      end
      if (scramble) begin
        addr_i = (i % 2 == 0) ? 32'h0000_00C0 : 32'h0000_40C0;
        data_i = {8{$urandom}};
        write_i = ~write_i;
      end
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL ack_timeout actual=none required=ack");
    end
    if (!keep_en) begin
      enable_i = 1'b0;
      @(negedge clk_i);
    end
  endtask

  initial begin
    rst_i = 1'b1;
    enable_i = 0; write_i = 0; addr_i = '0; data_i = '0;
    en2 = 0; wr2 = 0; a2 = '0; d2 = '0;
    model_dout = '0;
    for (int i = 0; i < 512; i++) model_mem[i] = '0;
    repeat (3) @(negedge clk_i);
    chk("rst_ack", {255'b0, ack_o}, 256'd0);
    chk("rst_busy", {255'b0, busy_o}, 256'd0);
    chk("rst_data", data_o, 256'd0);
    rst_i = 1'b0;
    @(negedge clk_i);

    // Preload lines through the write port.
    req(1'b1, 32'h0000_0060, {8{32'hDEADBEEF}}, 0, 0);
    req(1'b1, 32'h0000_0020, {8{32'h11111111}}, 0, 0);
    req(1'b1, 32'h0000_0040, {8{32'h22222222}}, 0, 0);
    req(1'b1, 32'h0000_00C0, {8{32'h66666666}}, 0, 0);
    req(1'b1, 32'h0000_00E0, 256'hA5, 0, 0);

    // Plain read of line 3.
    req(1'b0, 32'h0000_0060, '0, 0, 0);

    // Write then read line 2; write ack must leave data_o alone.
    req(1'b1, 32'h0000_0040, {8{32'h12345678}}, 0, 0);
    req(1'b0, 32'h0000_0040, '0, 0, 0);

    // Back-to-back reads of lines 1 and 2 with enable_i never dropped.
    req(1'b0, 32'h0000_0020, '0, 0, 1);
    req(1'b0, 32'h0000_0040, '0, 0, 0);
    chk("b2b_gap", 256'(last_ack - prev_ack), 256'(LAT + 1));

    // Inputs churn during WAIT of a write to line 5; only line 5 changes.
    req(1'b1, 32'h0000_00A0, {8{32'h55AA55AA}}, 1, 0);
    req(1'b0, 32'h0000_00A0, '0, 0, 0);
    req(1'b0, 32'h0000_00C0, '0, 0, 0);

    // Reset four cycles into a write to line 7.
    write_i = 1; addr_i = 32'h0000_00E0; data_i = {8{32'hF00DF00D}}; enable_i = 1;
    repeat (4) @(negedge clk_i);
    #2 rst_i = 1'b1;
    enable_i = 0;
    @(negedge clk_i);
    chk("abort_ack", {255'b0, ack_o}, 256'd0);
    chk("abort_busy", {255'b0, busy_o}, 256'd0);
    chk("abort_data", data_o, 256'd0);
    rst_i = 1'b0;
    model_dout = '0;
    repeat (LAT + 2) @(negedge clk_i);
    chk("abort_no_ack", {255'b0, ack_o}, 256'd0);
    req(1'b0, 32'h0000_00E0, '0, 0, 0);

    // Aliased address hits line 3.
    req(1'b0, 32'h0000_4060, '0, 0, 0);

    // LATENCY = 2 instance.
    en2 = 1; wr2 = 1; a2 = 32'h0000_0060; d2 = {8{32'hCAFEF00D}};
    @(negedge clk_i);
    chk("l2_wait", {254'b0, ack2, busy2}, 256'd1);
    @(negedge clk_i);
    chk("l2_write_ack", {255'b0, ack2}, 256'd1);
    en2 = 0;
    @(negedge clk_i);
    chk("l2_ack_drop", {254'b0, ack2, busy2}, 256'd0);
    en2 = 1; wr2 = 0;
    @(negedge clk_i);
    @(negedge clk_i);
    chk("l2_read_ack", {255'b0, ack2}, 256'd1);
    chk("l2_read_data", dout2, {8{32'hCAFEF00D}});
    en2 = 0;

    repeat (3) @(negedge clk_i);
    chk("queue_drained", 256'(exp_q.size()), 256'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
